// File: rtl/fp_mul_arbiter_if.sv
// rtl/fp_mul_arbiter_if.sv - requester and multiplier handshake bundle for fp_mul_arbiter
interface fp_mul_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_op_a;
    logic [32*NUM_REQ-1:0] req_op_b;
    logic [NUM_REQ-1:0]    req_precision;
    logic [NUM_REQ-1:0]    req_round;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [31:0]           rsp_result;
    logic [4:0]            rsp_flags;
    logic                  mul_start;
    logic                  mul_ready;
    logic [31:0]           mul_op_a;
    logic [31:0]           mul_op_b;
    logic                  mul_precision;
    logic                  mul_round;
    logic                  mul_valid;
    logic                  mul_ready_in;
    logic [31:0]           mul_result;
    logic [4:0]            mul_flags;

    modport master (
        output req_valid, req_op_a, req_op_b, req_precision, req_round, rsp_ready,
               mul_ready, mul_valid, mul_result, mul_flags,
        input  req_ready, rsp_valid, rsp_result, rsp_flags,
               mul_start, mul_op_a, mul_op_b, mul_precision, mul_round, mul_ready_in
    );

    modport slave (
        input  req_valid, req_op_a, req_op_b, req_precision, req_round, rsp_ready,
               mul_ready, mul_valid, mul_result, mul_flags,
        output req_ready, rsp_valid, rsp_result, rsp_flags,
               mul_start, mul_op_a, mul_op_b, mul_precision, mul_round, mul_ready_in
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin share of one fp_multiplier with in-order tag FIFO; FP_MUL_ARB_PERF_EN adds perf counters
module fp_mul_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic            clk,
    input  logic            rst,
    fp_mul_arbiter_if.slave bus,
    output logic            err_orphan
`ifdef FP_MUL_ARB_PERF_EN
    ,
    output logic [31:0]     perf_issue,
    output logic [31:0]     perf_stall
`endif
);
    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W-1:0]   lane;
    logic [TAG_W-1:0]   head;
    logic [TAG_W-1:0]   tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic               can_issue;
    logic               issue;
    logic               pop;
    logic               fifo_empty;

    assign fifo_empty = (count == '0);
    assign can_issue  = bus.mul_ready && (count < CNT_W'(MAX_INFLIGHT));
    assign head       = tag_mem[rd_ptr];

    // Rotating scan starting at rr_ptr; first valid lane wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant     = '0;
        lane      = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && bus.req_valid[lane]) begin
                grant_any = 1'b1;
                grant_idx = lane;
            end
            lane = (lane == TAG_W'(NUM_REQ - 1)) ? '0 : lane + TAG_W'(1);
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    assign bus.req_ready = grant & {NUM_REQ{can_issue}};
    assign issue         = |bus.req_ready;
    assign bus.mul_start = issue;

    always_comb begin
        bus.mul_op_a      = bus.req_op_a[31:0];
        bus.mul_op_b      = bus.req_op_b[31:0];
        bus.mul_precision = bus.req_precision[0];
        bus.mul_round     = bus.req_round[0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_any && grant_idx == TAG_W'(i)) begin
                bus.mul_op_a      = bus.req_op_a[32*i +: 32];
                bus.mul_op_b      = bus.req_op_b[32*i +: 32];
                bus.mul_precision = bus.req_precision[i];
                bus.mul_round     = bus.req_round[i];
            end
        end
    end

    // With nothing outstanding, results are drained unconditionally so a stale one cannot wedge the multiplier.
    always_comb begin
        bus.rsp_valid = '0;
        if (bus.mul_valid && !fifo_empty) bus.rsp_valid[head] = 1'b1;
    end

    assign bus.mul_ready_in = fifo_empty ? 1'b1 : bus.rsp_ready[head];
    assign bus.rsp_result   = bus.mul_result;
    assign bus.rsp_flags    = bus.mul_flags;
    assign pop              = bus.mul_valid && bus.mul_ready_in && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (issue) begin
                tag_mem[wr_ptr] <= grant_idx;
                wr_ptr          <= wr_ptr + PTR_W'(1);
                rr_ptr          <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (issue && !pop)      count <= count + CNT_W'(1);
            else if (pop && !issue) count <= count - CNT_W'(1);
            if (bus.mul_valid && fifo_empty) err_orphan <= 1'b1;
        end
    end

`ifdef FP_MUL_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (issue && perf_issue != 32'hFFFF_FFFF) perf_issue <= perf_issue + 32'd1;
            if (|bus.req_valid && !can_issue && perf_stall != 32'hFFFF_FFFF) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule
